// File: rtl/ega_video_pkg.sv
// Shared EGA video definitions: default 640x350@70 timing, colour types
// used by the scan-out and palette blocks, and small timing helpers.
package ega_video_pkg;

  // Default 640x350@70 raster timing (pixels / lines).
  localparam int EGA_H_VISIBLE = 640;
  localparam int EGA_H_FRONT   = 16;
  localparam int EGA_H_SYNC    = 96;
  localparam int EGA_H_BACK    = 48;
  localparam int EGA_V_VISIBLE = 350;
  localparam int EGA_V_FRONT   = 37;
  localparam int EGA_V_SYNC    = 2;
  localparam int EGA_V_BACK    = 60;
  localparam int EGA_VRAM_ADDR_W = 17;

  // Ticks between a pixel's counter position and its appearance at the output.
  localparam int SCAN_DELAY = 3;

  typedef logic [3:0] palette_index_t;
  typedef logic [5:0] rgb6_t;

  // Counter regions, in raster order.
  typedef enum logic [1:0] {
    REGION_VISIBLE = 2'd0,
    REGION_FRONT   = 2'd1,
    REGION_SYNC    = 2'd2,
    REGION_BACK    = 2'd3
  } region_t;

  // Per-pixel attributes carried down the delay line alongside the fetch.
  // live=0 marks entries injected by reset so they never show a colour.
  typedef struct packed {
    logic live;
    logic blank;
    logic hsync_act;
    logic vsync_act;
    logic odd;
  } scan_tag_t;

  localparam scan_tag_t SCAN_TAG_FLUSH = '{
    live: 1'b0, blank: 1'b1, hsync_act: 1'b0, vsync_act: 1'b0, odd: 1'b0
  };

  function automatic int h_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int v_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int cnt_width(int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  // Which region a counter value falls into, given the region widths.
  function automatic region_t region_of(int cnt, int vis, int fp, int sync);
    if (cnt < vis)             return REGION_VISIBLE;
    if (cnt < vis + fp)        return REGION_FRONT;
    if (cnt < vis + fp + sync) return REGION_SYNC;
    return REGION_BACK;
  endfunction

endpackage

// File: rtl/ega_scanout_controller_if.sv
// VRAM read port between the scan-out controller (master) and the
// synchronous video RAM (slave). Read data is valid one clk after vram_rd.
interface ega_scanout_controller_if #(
  parameter int ADDR_W = 17
);
  logic              vram_rd;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_rdata;

  modport master (output vram_rd, output vram_addr, input vram_rdata);
  modport slave  (input vram_rd, input vram_addr, output vram_rdata);
endinterface

// File: rtl/ega_sync_counter.sv
// Horizontal/vertical raster counters with region decode and the
// end-of-visible-frame pulse. Counters advance only on pix_ce ticks.
module ega_sync_counter
  import ega_video_pkg::*;
#(
  parameter int H_VISIBLE = EGA_H_VISIBLE,
  parameter int H_FRONT   = EGA_H_FRONT,
  parameter int H_SYNC    = EGA_H_SYNC,
  parameter int H_BACK    = EGA_H_BACK,
  parameter int V_VISIBLE = EGA_V_VISIBLE,
  parameter int V_FRONT   = EGA_V_FRONT,
  parameter int V_SYNC    = EGA_V_SYNC,
  parameter int V_BACK    = EGA_V_BACK
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    pix_ce,
  output region_t h_region,
  output region_t v_region,
  output logic    h_odd,
  output logic    frame_wrap,
  output logic    frame_done
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int H_W = cnt_width(H_TOTAL);
  localparam int V_W = cnt_width(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS_LAST = H_W'(H_VISIBLE - 1);
  localparam logic [V_W-1:0] V_VIS_LAST = V_W'(V_VISIBLE - 1);

  logic [H_W-1:0] h_cnt_reg;
  logic [V_W-1:0] v_cnt_reg;
  logic           frame_done_reg;
  logic           at_last_visible;

  // Region decode and wrap detection from the current counter values.
  always_comb begin
    h_region        = region_of(int'(h_cnt_reg), H_VISIBLE, H_FRONT, H_SYNC);
    v_region        = region_of(int'(v_cnt_reg), V_VISIBLE, V_FRONT, V_SYNC);
    h_odd           = h_cnt_reg[0];
    frame_wrap      = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);
    at_last_visible = (h_cnt_reg == H_VIS_LAST) && (v_cnt_reg == V_VIS_LAST);
  end

  // Raster counters; v advances when h wraps. frame_done marks the clk
  // after the tick that leaves the last visible pixel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_reg      <= '0;
      v_cnt_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= pix_ce && at_last_visible;
      if (pix_ce) begin
        if (h_cnt_reg == H_LAST) begin
          h_cnt_reg <= '0;
          v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
          h_cnt_reg <= h_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign frame_done = frame_done_reg;

endmodule

// File: rtl/ega_scanout_controller.sv
// EGA raster scan-out: fetches packed 4-bpp bytes from VRAM (one read per
// two pixels), unpacks them high nibble first, and presents one palette
// index per pixel tick with sync/blank delayed to stay aligned.
// Optional feature macro: EGA_SCANOUT_BORDER_EN adds a border_index input
// shown during the porches (sync still shows 0).
module ega_scanout_controller
  import ega_video_pkg::*;
#(
  parameter int H_VISIBLE = EGA_H_VISIBLE,
  parameter int H_FRONT   = EGA_H_FRONT,
  parameter int H_SYNC    = EGA_H_SYNC,
  parameter int H_BACK    = EGA_H_BACK,
  parameter int V_VISIBLE = EGA_V_VISIBLE,
  parameter int V_FRONT   = EGA_V_FRONT,
  parameter int V_SYNC    = EGA_V_SYNC,
  parameter int V_BACK    = EGA_V_BACK,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b0,
  parameter int ADDR_W    = EGA_VRAM_ADDR_W
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            pix_ce,
  ega_scanout_controller_if.master        vram,
  output palette_index_t                  pixel_index,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            blank,
  output logic                            frame_done
`ifdef EGA_SCANOUT_BORDER_EN
  ,
  input  palette_index_t                  border_index
`endif
);

  region_t h_region;
  region_t v_region;
  logic    h_odd;
  logic    frame_wrap;

  ega_sync_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .h_region   (h_region),
    .v_region   (v_region),
    .h_odd      (h_odd),
    .frame_wrap (frame_wrap),
    .frame_done (frame_done)
  );

  logic              visible;
  logic              fetch;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic              fetch_d1_reg;
  logic [7:0]        byte_q_reg;
  scan_tag_t         tag_now;
  scan_tag_t         tag_reg [SCAN_DELAY];
  palette_index_t    pixel_reg;
  palette_index_t    pixel_next;

  // Fetch strobe: one clk per byte, on the even pixel of each visible pair.
  always_comb begin
    visible = (h_region == REGION_VISIBLE) && (v_region == REGION_VISIBLE);
    fetch   = pix_ce && visible && !h_odd;
    tag_now = '{
      live:      1'b1,
      blank:     !visible,
      hsync_act: (h_region == REGION_SYNC),
      vsync_act: (v_region == REGION_SYNC),
      odd:       h_odd
    };
  end

  assign vram.vram_rd   = fetch;
  assign vram.vram_addr = addr_cnt_reg;

  // Linear byte address: bumps after every fetch, restarts at frame wrap,
  // so the address follows (y*H_VISIBLE+x)/2 without a multiplier.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_cnt_reg <= '0;
    end else if (pix_ce) begin
      if (frame_wrap) begin
        addr_cnt_reg <= '0;
      end else if (fetch) begin
        addr_cnt_reg <= addr_cnt_reg + 1'b1;
      end
    end
  end

  // Capture the RAM byte on the tick after its fetch; the RAM holds its
  // output while idle, so slow pix_ce rates still see the right data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_d1_reg <= 1'b0;
      byte_q_reg   <= '0;
    end else if (pix_ce) begin
      fetch_d1_reg <= fetch;
      if (fetch_d1_reg) begin
        byte_q_reg <= vram.vram_rdata;
      end
    end
  end

  // Attribute delay line; reset fills it with blank, non-live entries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SCAN_DELAY; i++) begin
        tag_reg[i] <= SCAN_TAG_FLUSH;
      end
    end else if (pix_ce) begin
      tag_reg[0] <= tag_now;
      for (int i = 1; i < SCAN_DELAY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  // Nibble select for the pixel entering the output stage; uses byte_q
  // before this edge's reload, which is what the odd pixel needs.
  always_comb begin
    pixel_next = '0;
    if (tag_reg[SCAN_DELAY-2].live && !tag_reg[SCAN_DELAY-2].blank) begin
      pixel_next = tag_reg[SCAN_DELAY-2].odd ? byte_q_reg[3:0] : byte_q_reg[7:4];
    end
`ifdef EGA_SCANOUT_BORDER_EN
    if (tag_reg[SCAN_DELAY-2].live && tag_reg[SCAN_DELAY-2].blank &&
        !tag_reg[SCAN_DELAY-2].hsync_act && !tag_reg[SCAN_DELAY-2].vsync_act) begin
      pixel_next = border_index;
    end
`endif
  end

  // Output pixel register, advancing in step with the last delay stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pixel_reg <= '0;
    end else if (pix_ce) begin
      pixel_reg <= pixel_next;
    end
  end

  assign pixel_index = pixel_reg;
  assign blank       = tag_reg[SCAN_DELAY-1].blank;
  assign hsync       = tag_reg[SCAN_DELAY-1].hsync_act ? HSYNC_POL : !HSYNC_POL;
  assign vsync       = tag_reg[SCAN_DELAY-1].vsync_act ? VSYNC_POL : !VSYNC_POL;

endmodule

// File: tb/tb_ega_scanout_controller.sv
// Scoreboard bench for ega_scanout_controller on a reduced raster so whole
// frames fit in a short run. The stimulus side pushes the expected output
// for every pixel tick; a negedge monitor pops and compares.
module tb_ega_scanout_controller;
  import ega_video_pkg::*;

  localparam int HV = 24, HF = 4, HS = 6, HB = 6;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME  = HT * VT;
  localparam int NBYTES = HV * VV / 2;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam logic [3:0] BORDER = 4'h9;

  typedef struct packed {
    logic [3:0] pix;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fd;
  } obs_t;

  localparam obs_t RESET_OBS = '{pix: 4'h0, blank: 1'b1, hs: !HPOL, vs: !VPOL, fd: 1'b0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_ce = 1'b0;
  palette_index_t pixel_index;
  logic hsync, vsync, blank, frame_done;
`ifdef EGA_SCANOUT_BORDER_EN
  palette_index_t border_index = BORDER;
`endif

  ega_scanout_controller_if #(.ADDR_W(17)) vif ();

  ega_scanout_controller #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .ADDR_W (17)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .vram        (vif),
    .pixel_index (pixel_index),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .frame_done  (frame_done)
`ifdef EGA_SCANOUT_BORDER_EN
    ,
    .border_index(border_index)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous VRAM model: registered read, holds output when idle.
  logic [7:0] mem [NBYTES];
  always @(posedge clk) begin
    if (vif.vram_rd) vif.vram_rdata <= mem[int'(vif.vram_addr) % NBYTES];
  end

  obs_t exp_q[$];
  int n;
  int errors = 0;
  int checks = 0;

  // Expected outputs during the period after the n-th pix_ce edge since
  // reset release: pixel at raster position n-3, frame_done when the
  // edge left the last visible pixel.
  function automatic obs_t model_tick(int k);
    obs_t o;
    int p, h, v;
    logic hs_act, vs_act;
    logic [7:0] b;
    o = RESET_OBS;
    p = (k - 1) % FRAME;
    o.fd = (p == (VV - 1) * HT + (HV - 1));
    if (k >= 3) begin
      p = (k - 3) % FRAME;
      h = p % HT;
      v = p / HT;
      hs_act = (h >= HV + HF) && (h < HV + HF + HS);
      vs_act = (v >= VV + VF) && (v < VV + VF + VS);
      o.blank = !((h < HV) && (v < VV));
      o.hs = hs_act ? HPOL : !HPOL;
      o.vs = vs_act ? VPOL : !VPOL;
      if (!o.blank) begin
        b = mem[(v * HV + h) / 2];
        o.pix = (h % 2 == 0) ? b[7:4] : b[3:0];
      end
`ifdef EGA_SCANOUT_BORDER_EN
      if (o.blank && !hs_act && !vs_act) o.pix = BORDER;
`endif
    end
    return o;
  endfunction

  task automatic drive(input logic ce, input logic rn);
    pix_ce = ce;
    reset_n = rn;
    if (!rn) begin
      n = 0;
    end else if (ce) begin
      n++;
      exp_q.push_back(model_tick(n));
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per pix_ce tick; between ticks the
  // outputs must hold the last expected value with frame_done low.
  logic ce_s, rn_s;
  bit started = 1'b0;
  int pos_n = 0;
  obs_t cur = RESET_OBS;
  always @(posedge clk) begin
    ce_s <= pix_ce;
    rn_s <= reset_n;
  end

  always @(negedge clk) begin
    obs_t got;
    int p, h, v;
    logic exp_rd;
    logic [17:0] exp_f, got_f;
    got = '{pix: pixel_index, blank: blank, hs: hsync, vs: vsync, fd: frame_done};
    if (rn_s === 1'b0) begin
      cur = RESET_OBS;
      pos_n = 0;
      started = 1'b1;
    end else if (started && ce_s) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_underflow tick=%0d got=empty required=entry", pos_n);
      end else begin
        cur = exp_q.pop_front();
      end
      pos_n++;
    end else begin
      cur.fd = 1'b0;
    end
    if (started) begin
      checks++;
      if (got !== cur) begin
        errors++;
        $display("FAIL out tick=%0d got pix=%h blank=%b hs=%b vs=%b fd=%b required pix=%h blank=%b hs=%b vs=%b fd=%b",
                 pos_n, got.pix, got.blank, got.hs, got.vs, got.fd,
                 cur.pix, cur.blank, cur.hs, cur.vs, cur.fd);
      end
    end
    if (started && reset_n) begin
      p = pos_n % FRAME;
      h = p % HT;
      v = p / HT;
      exp_rd = pix_ce && (h < HV) && (v < VV) && (h % 2 == 0);
      exp_f = {exp_rd, exp_rd ? 17'((v * HV + h) / 2) : 17'd0};
      got_f = {vif.vram_rd, vif.vram_rd ? vif.vram_addr : 17'd0};
      checks++;
      if (got_f !== exp_f) begin
        errors++;
        $display("FAIL fetch tick=%0d ce=%b got rd=%b addr=%0d required rd=%b addr=%0d",
                 pos_n, pix_ce, got_f[17], got_f[16:0], exp_f[17], exp_f[16:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    n = 0;
    // Reset with pix_ce high: reset must win.
    repeat (3) drive(1'b1, 1'b0);
    // Constant pix_ce for a frame and a half.
    for (int i = 0; i < FRAME + FRAME / 2; i++) drive(1'b1, 1'b1);
    // pix_ce one clk in four for a full frame of ticks.
    for (int i = 0; i < 4 * FRAME; i++) drive(logic'(i % 4 == 3), 1'b1);
    // Random pix_ce.
    for (int i = 0; i < 1500; i++) drive(logic'($urandom_range(0, 2) != 0), 1'b1);
    // Mid-frame reset, then restart from pixel (0,0).
    repeat (2) drive(1'b1, 1'b0);
    for (int i = 0; i < FRAME + 100; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 1500; i++) drive(logic'($urandom_range(0, 3) == 0), 1'b1);
    repeat (8) drive(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d left required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ega_scanout_controller.md
# ega_scanout_controller

Raster scan-out engine for the EGA 640x350 display path. Generates horizontal/vertical timing, fetches 4-bpp packed pixel bytes from a synchronous video RAM, and emits one 4-bit palette index per pixel tick to `ega_colour_palette_logic`. Sync and blank outputs are delayed to stay aligned with the index.

## Interface
- `H_VISIBLE`, default 640: visible pixels per line; must be even.
- `H_FRONT` / `H_SYNC` / `H_BACK`, default 16 / 96 / 48: horizontal porch and sync widths, in pixels.
- `V_VISIBLE`, default 350: visible lines.
- `V_FRONT` / `V_SYNC` / `V_BACK`, default 37 / 2 / 60: vertical porch and sync widths, in lines.
- `HSYNC_POL` / `VSYNC_POL`, default 1 / 0: active level of each sync output.
- `ADDR_W`, default 17: VRAM byte-address width.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous reset, active low.
- `pix_ce` in 1: pixel-tick enable; all state advances only on a `clk` edge with `pix_ce`=1.
- `vram_rd` out 1: read strobe to VRAM.
- `vram_addr` out ADDR_W: VRAM byte address.
- `vram_rdata` in 8: read data, valid one clk after the read. The RAM holds its output while `vram_rd`=0.
- `pixel_index` out 4: palette index.
- `hsync`, `vsync` out 1: sync outputs.
- `blank` out 1: 1 outside the visible area.
- `frame_done` out 1: one-clk pulse at the end of the last visible pixel's tick.
- `border_index` in 4: border colour; present only with `EGA_SCANOUT_BORDER_EN`.

## Operation
- Counters: `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters. `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
- Counter regions, in order: visible, front porch, sync, back porch. Visible means `h_cnt`<H_VISIBLE and `v_cnt`<V_VISIBLE.
- `hsync` is at HSYNC_POL while `h_cnt` is in [H_VISIBLE+H_FRONT, +H_SYNC). `vsync` follows the same rule on `v_cnt`.
- Fetch: `vram_rd` = `pix_ce` & visible & `h_cnt`[0]==0. This is combinational, so the strobe is high for one clk per byte.
- `vram_addr` comes from the byte counter `addr_cnt`. It increments after each fetch and clears when `v_cnt` wraps to 0, so addr = (y*H_VISIBLE+x)/2. There is no multiplier.
- Packing: the high nibble of a byte is the even pixel x; the low nibble is x+1.
- Byte register `byte_q` loads `vram_rdata` on the tick after a fetch tick.
- Output register:
  - For a delayed-even pixel, loads `byte_q[7:4]`; for a delayed-odd pixel, `byte_q[3:0]`.
  - It reads the pre-update `byte_q` on the same edge that reloads `byte_q`.
- `blank`, `hsync`, `vsync` and the pixel parity pass through a 3-stage delay line clocked by `pix_ce`.
- When `blank`=1, `pixel_index` = 0.
- `frame_done` pulses for one clk on the tick where the counters leave (H_VISIBLE-1, V_VISIBLE-1). It is not delayed.
- `pix_ce`=0: all counters, pipeline stages and outputs hold; `vram_rd`=0.
- Reset (`reset_n`=0 at a clk edge) overrides `pix_ce` and applies:
  - `h_cnt`=`v_cnt`=`addr_cnt`=0 and the delay line is flushed to blank;
  - `pixel_index`=0, `blank`=1, `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL, `frame_done`=0.
  - Reset mid-frame restarts at pixel (0,0); the first 3 ticks after release show blank.

## Timing
- Latency: `pixel_index` for pixel (x,y) is valid during the pixel period in which `h_cnt`==x+3 (counter-relative, with wrap).
- `hsync`/`vsync`/`blank` carry the same 3-tick lag, so they are aligned with `pixel_index`.
- Fetch for byte x/2 is issued in period x. Its data is registered at the end of period x+1.
- Line wrap: the last fetch is at x=H_VISIBLE-2. Pipeline draining overlaps the front porch, so no data is lost.
- Read throughput: one VRAM read per 2 pixel ticks, never back-to-back clks.

## Configuration
- Macro: `EGA_SCANOUT_BORDER_EN`.
- Defined:
  - `border_index` port exists.
  - During the front/back porch regions (not sync), `pixel_index` = `border_index`, sampled at the output stage.
  - During sync, `pixel_index` = 0.
- Undefined: no `border_index` port; `pixel_index` = 0 whenever `blank`=1.

## Structure
- Package `ega_video_pkg` holds:
  - the default timing constants (640x350@70);
  - `palette_index_t` (logic [3:0]) and `rgb6_t` (logic [5:0]), shared with the palette block;
  - H_TOTAL/V_TOTAL as localparam functions.
- Sub-module `ega_sync_counter` owns the h/v counters, region decode and `frame_done`. The top level owns fetch, the byte register and the delay line.

## Test plan
- After reset release with `pix_ce`=1 constantly:
  - `hsync` first asserts when `h_cnt`=656+3 (rises 659 ticks after release) and lasts 96 ticks;
  - line period 800 ticks, frame 449 lines.
- VRAM byte 0 = 0xA5, byte 1 = 0x3C: pixels (0,0..3) appear as indices A, 5, 3, C on ticks 3..6 with `blank`=0.
- Addressing: the first fetch of line 1 has `vram_addr`=320; the last fetch of the frame has `vram_addr`=111999; the next frame's first fetch has `vram_addr`=0.
- `pix_ce` toggling 1-of-4: output sequence is identical to the constant-`pix_ce` run, each value held 4 clks, and `vram_rd` is never high when `pix_ce`=0.
- Reset at (x=100, y=50): the next output is blank for 3 ticks, then pixel (0,0) with `vram_addr`=0.
- With `EGA_SCANOUT_BORDER_EN` and `border_index`=0x9: front porch shows 9 and sync shows 0. Without the macro, both show 0.
